// File: rtl/sram_banked.sv
// Banked single-port SRAM with byte-enable writes, a two-stage read path
// feeding a 2-entry in-order response buffer, and a row-at-a-time zero-fill.
// Address LSBs pick the bank, the remaining bits pick the row.
module sram_banked #(
   parameter  int DATA_W = 64,
   parameter  int BANKS  = 32,
   parameter  int DEPTH  = 4096,
   localparam int BK_W   = $clog2(BANKS),
   localparam int ROW_W  = $clog2(DEPTH),
   localparam int ADDR_W = BK_W + ROW_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              clr_start,
   output logic              clr_busy
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                        r_state, w_state_nxt;
   logic [ROW_W-1:0]              r_row;
   logic [1:0]                    r_out_cnt;
   logic                          w_idle, w_fire, w_wr, w_rd, w_rsp_fire;
   logic [BK_W-1:0]               w_bank;
   logic [ROW_W-1:0]              w_row;
   logic [DATA_W-1:0]             w_wmask;
   logic [BANKS-1:0][DATA_W-1:0]  w_bank_q;
   logic                          r_s1_vld;
   logic [BK_W-1:0]               r_s1_bank;
   logic [DATA_W-1:0]             r_buf [2];
   logic                          r_wp, r_rp;
   logic [1:0]                    r_bcnt;

   assign w_bank     = req_addr[BK_W-1:0];
   assign w_row      = req_addr[ADDR_W-1:BK_W];
   assign w_fire     = req_valid & req_ready;
   assign w_wr       = w_fire & req_we;
   assign w_rd       = w_fire & ~req_we;
   assign w_rsp_fire = rsp_valid & rsp_ready;
   assign rsp_valid  = (r_bcnt != 2'd0);
   assign rsp_data   = r_buf[r_rp];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state: a clear request only counts from IDLE, so a repeat pulse
   // during CLEAR cannot restart the fill
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (clr_start) w_state_nxt = CLEAR;
         CLEAR:   if (r_row == ROW_W'(DEPTH - 1)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs; ready is masked by reset so it is low while rst is held
   always_comb begin
      w_idle    = (r_state == IDLE);
      clr_busy  = (r_state == CLEAR);
      req_ready = rst & w_idle & (r_out_cnt < 2'd2);
   end

   // Row counter advances once per CLEAR cycle and wraps back to 0 on the last row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_row <= '0;
      else if (clr_busy) r_row <= r_row + 1'b1;
   end

   // Outstanding reads: pipeline stage plus response buffer, never above 2
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_out_cnt <= 2'd0;
      else begin
         case ({w_rd, w_rsp_fire})
            2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
            2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

   // Array-read stage tracking: which bank's read register holds the data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_bank <= '0;
      end else begin
         r_s1_vld  <= w_rd;
         r_s1_bank <= w_bank;
      end
   end

   // Output stage: 2-entry FIFO; head entry is only rewritten after it pops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_bcnt   <= 2'd0;
      end else begin
         if (r_s1_vld) begin
            r_buf[r_wp] <= w_bank_q[r_s1_bank];
            r_wp        <= ~r_wp;
         end
         if (w_rsp_fire) r_rp <= ~r_rp;
         r_bcnt <= r_bcnt + {1'b0, r_s1_vld} - {1'b0, w_rsp_fire};
      end
   end

   for (genvar j = 0; j < BE_W; j++) begin : g_mask
      assign w_wmask[j*8 +: 8] = {8{req_be[j]}};
   end

   for (genvar g = 0; g < BANKS; g++) begin : g_bank
      logic [DATA_W-1:0] r_bank [DEPTH];
      logic [DATA_W-1:0] r_q;
      logic              w_sel;

      assign w_sel       = (w_bank == BK_W'(g));
      assign w_bank_q[g] = r_q;

      // Bank storage (not reset): zero-fill has priority, else masked byte write;
      // read data is registered into the bank's read register
      always_ff @(posedge clk) begin
         if (clr_busy)
            r_bank[r_row] <= '0;
         else if (w_wr && w_sel)
            r_bank[w_row] <= (r_bank[w_row] & ~w_wmask) | (req_wdata & w_wmask);
         if (w_rd && w_sel)
            r_q <= r_bank[w_row];
      end
   end

endmodule

// File: tb/tb_sram_banked.sv
// Directed plus randomized bench for sram_banked against a flat word-array
// model and an in-order expected-response queue.
module tb_sram_banked;
   localparam int DW = 32, NB = 4, DP = 8, AW = 5, BW = 4, NW = NB * DP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_be;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          clr_start, clr_busy;

   logic [DW-1:0] model [NW];
   logic [DW-1:0] expq [$];
   int            errors = 0;
   int            checks = 0;
   bit            rnd_rdy = 1'b0;

   sram_banked #(.DATA_W(DW), .BANKS(NB), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .clr_start(clr_start), .clr_busy(clr_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   function automatic void mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input logic [BW-1:0] be);
      logic [DW-1:0] w;
      w = model[a];
      for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
      model[a] = w;
   endfunction

   function automatic void mclear();
      for (int a = 0; a < NW; a++) model[a] = '0;
   endfunction

   // Response monitor: every handshake must match the oldest expected read
   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         checks++;
         assert (expq.size() > 0) else begin
            errors++;
            $error("FAIL rsp_extra: observed=%h expected=no response", rsp_data);
         end
         if (expq.size() > 0) chk("rsp_data", rsp_data, expq.pop_front());
      end
   end

   task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be, input bit push);
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      while (!req_ready && n < 200) begin tick(); n++; end
      chk("req_accept", {31'd0, req_ready}, 32'd1);
      if (req_ready) begin
         if (we) mwrite(a, d, be);
         else if (push) expq.push_back(model[a]);
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rnd_rdy = 1'b0;
      rsp_ready = 1'b1;
      while (expq.size() != 0 && n < 200) begin tick(); n++; end
      chk("drain_empty", expq.size(), 0);
      tick(); tick();
      chk("drain_idle", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic fill();
      for (int a = 0; a < NW; a++) do_req(1'b1, AW'(a), $urandom, 4'hF, 1'b0);
   endtask

   task automatic read_all();
      rsp_ready = 1'b1;
      for (int a = 0; a < NW; a++) do_req(1'b0, AW'(a), '0, '0, 1'b1);
      drain();
   endtask

   initial begin
      int acc, n;
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 0; clr_start = 0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
      rst = 1'b1;
      #1 chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
      tick();

      // Full zero-fill: busy for exactly DP cycles, requests blocked
      clr_start = 1'b1; tick(); clr_start = 1'b0;
      for (int k = 0; k < DP; k++) begin
         chk("clr_busy", {31'd0, clr_busy}, 32'd1);
         chk("clr_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      chk("clr_done", {31'd0, clr_busy}, 32'd0);
      mclear();
      read_all();

      // Full write then read: data two cycles after acceptance
      do_req(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0);
      rsp_ready = 1'b0;
      do_req(1'b0, 5'd5, '0, '0, 1'b1);
      chk("lat_n1", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("lat_n2", {31'd0, rsp_valid}, 32'd1);
      chk("lat_data", rsp_data, model[5]);
      drain();

      // Byte-lane write, then an all-zero-enable write that must change nothing
      do_req(1'b1, 5'd5, 32'h0000AA00, 4'b0010, 1'b0);
      do_req(1'b0, 5'd5, '0, '0, 1'b1);
      do_req(1'b1, 5'd5, 32'h12345678, 4'b0000, 1'b0);
      do_req(1'b0, 5'd5, '0, '0, 1'b1);
      drain();

      // Back-pressure: only two reads fit while the consumer stalls
      rsp_ready = 1'b0; acc = 0;
      req_valid = 1'b1; req_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req_addr = AW'(i * 3 + 1);
         if (req_ready) begin acc++; expq.push_back(model[req_addr]); end
         tick();
      end
      req_valid = 1'b0;
      chk("bp_accepts", acc, 2);
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      chk("bp_hold0", rsp_data, expq[0]);
      tick();
      chk("bp_hold1", rsp_data, expq[0]);
      rsp_ready = 1'b1;
      tick();
      chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
      drain();

      // Random mixed traffic with random consumer stalls
      fill();
      rnd_rdy = 1'b1;
      repeat (150) begin
         do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), $urandom,
                BW'($urandom_range(0, 15)), 1'b1);
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain();

      // Read accepted in the clr_start cycle returns pre-clear data
      fill();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7; clr_start = 1'b1;
      chk("same_cyc_rd_ready", {31'd0, req_ready}, 32'd1);
      expq.push_back(model[7]);
      tick();
      req_valid = 1'b0; clr_start = 1'b0;
      mclear();
      n = 0;
      while (clr_busy && n < 100) begin n++; tick(); end
      chk("clr_len_rd", n, DP);
      drain();

      // Write in the clr_start cycle plus a repeat pulse mid-fill
      fill();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd13; req_wdata = $urandom | 32'd1;
      req_be = 4'hF; clr_start = 1'b1;
      tick();
      req_valid = 1'b0; clr_start = 1'b0;
      mclear();
      n = 0;
      while (clr_busy && n < 100) begin
         clr_start = (n == 3);
         n++;
         tick();
      end
      clr_start = 1'b0;
      chk("clr_len_restart", n, DP);
      read_all();

      // Reset three cycles into a fill with a read response in flight
      fill();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd2; clr_start = 1'b1;
      tick();
      req_valid = 1'b0; clr_start = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_clr_busy", {31'd0, clr_busy}, 32'd0);
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
      for (int a = 0; a < 3 * NB; a++) model[a] = '0;
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      read_all();

      repeat (3) tick();
      chk("final_queue", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
